multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

- Moore-style control FSM that sequences the shared multi-cycle RV32I datapath.
- Covers the same instruction subset as the single-cycle decoder: R-type, load, store and branch-equal.
- One unified instruction/data memory is reached through a req/ready handshake.
- The block drives all datapath strobes and mux selects per phase. It replaces per-instruction combinational control once the datapath is split into FETCH/DECODE/EXECUTE/MEM/WB steps.

## Interface
Parameters:
- N, 32, instruction width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- ir  in  N  instruction register contents; only ir[6:2] is decoded
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the transfer this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write enable; valid only while mem_req=1
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR and OLDPC
- pc_write  out  1  load PC
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut
- alu_src_a  out  2  operand A select: 00 = PC, 01 = OLDPC, 10 = rs1
- alu_src_b  out  2  operand B select: 00 = rs2, 01 = constant 4, 10 = immediate
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct decode
- reg_write  out  1  register file write
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- illegal  out  1  sticky unsupported-opcode flag
- state  out  4  current state, for debug

## Operation
States, 4-bit encoding:

- FETCH (0)
  - Drives mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - While mem_ready=0: stays in FETCH, with ir_write=0 and pc_write=0.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then goes to DECODE.
- DECODE (1)
  - Drives alu_src_a=01, alu_src_b=10, alu_op=00, so the branch target lands in ALUOut.
  - Next state from ir[6:2]:
    - 01100 → EXEC_R
    - 00000 or 01000 → ADDR
    - 11000 → BRANCH
    - anything else → ILLEGAL
- ADDR (2)
  - Drives alu_src_a=10, alu_src_b=10, alu_op=00.
  - Next state: ir[6:2]=00000 → MEM_RD; otherwise → MEM_WR.
- MEM_RD (3)
  - Drives mem_req=1, iord=1, mem_we=0.
  - Holds until mem_ready=1, then goes to WB_MEM.
- MEM_WR (4)
  - Drives mem_req=1, iord=1, mem_we=1.
  - Holds until mem_ready=1, then goes to FETCH.
- WB_MEM (5)
  - Drives reg_write=1, mem_to_reg=1, then goes to FETCH.
- EXEC_R (6)
  - Drives alu_src_a=10, alu_src_b=00, alu_op=10, then goes to WB_ALU.
- WB_ALU (7)
  - Drives reg_write=1, mem_to_reg=0, then goes to FETCH.
- BRANCH (8)
  - Drives alu_src_a=10, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero.
  - funct3 is ignored; the only branch is BEQ. Then goes to FETCH.
- ILLEGAL (9)
  - Drives illegal=1 and all strobes 0. Stays here until reset.
- Codes 10–15 are unreachable; if reached, go to ILLEGAL.

Any output not listed for a state is 0.

## Timing
- The state register updates on the rising edge of clk.
- Outputs are combinational from state (plus mem_ready/zero where listed). While rst=0 they are forced to 0.
- Reset:
  - rst=0 at an edge loads FETCH and clears illegal.
  - Every output reads 0 while rst=0 (state reads 0 = FETCH).
  - The first mem_req appears in the first cycle with rst=1.
- Handshake:
  - A transfer completes in any cycle where mem_req=1 and mem_ready=1.
  - mem_req, mem_we and iord stay stable until completion.
  - mem_ready is ignored while mem_req=0.
  - There is no timeout; wait states are unbounded.
- Latency with zero wait states:
  - R-type: 4 cycles
  - Load: 5 cycles
  - Store: 4 cycles
  - Branch: 3 cycles
  - Each memory wait cycle adds 1.
- Reset mid-transaction:
  - mem_req drops in the same cycle rst goes low; the memory aborts the transfer.
  - No reg_write or pc_write is issued.
- zero is sampled only in BRANCH.
- ir is sampled only in DECODE and ADDR.

## Structure
- Shared header ctrl_defs.vh holds:
  - state codes
  - opcode constants (OP_R=5'b01100, OP_LOAD=5'b00000, OP_STORE=5'b01000, OP_BRANCH=5'b11000)
  - ALU_SRC_A, ALU_SRC_B and ALU_OP codes
- The decoder in datapath control also uses ctrl_defs.vh.
- Optional sub-module ctrl_opcode_class maps ir[6:2] to a one-hot class: {r, load, store, branch, bad}.
- Next-state logic and output logic are separate always blocks.

## Test plan
- R-type (0x002081B3, add x3,x1,x2), mem_ready always 1:
  - state sequence 0,1,6,7,0
  - reg_write=1 only in cycle 4, with mem_to_reg=0.
- Load (0x0000A183), mem_ready delayed 3 cycles in both FETCH and MEM_RD:
  - 11 cycles total
  - ir_write is a single pulse, and so is reg_write with mem_to_reg=1.
- Store (0x0030A023):
  - MEM_WR drives mem_req=1, mem_we=1, iord=1
  - no reg_write at any point.
- BEQ (0x00208463):
  - with zero=1: pc_write=1 and pc_src=1 in BRANCH
  - with zero=0: pc_write=0
  - both cases return to FETCH.
- Opcode 0x37 (LUI):
  - enters ILLEGAL; illegal=1 stays set for 20 cycles with all strobes 0
  - rst=0 clears it and resumes FETCH.
- rst=0 asserted during a MEM_RD wait:
  - all outputs 0 in the same cycle
  - state=FETCH after the edge
  - no reg_write is ever issued for the aborted load.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM:
// state codes, opcode classes and datapath select encodings.
package multi_cycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_ADDR    = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WR  = 4'd4,
        S_WB_MEM  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_BRANCH  = 4'd8,
        S_ILLEGAL = 4'd9
    } state_t;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_FUNCT   = 2'b10;

    typedef struct packed {
        logic r;
        logic load;
        logic store;
        logic branch;
        logic bad;
    } op_class_t;

endpackage

// File: rtl/multi_cycle_ctrl_opclass.sv
// One-hot opcode classifier for ir[6:2].
// Exactly one class bit is set for any input.
module multi_cycle_ctrl_opclass
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [4:0] op,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        unique case (1'b1)
            (op == OP_R):      cls.r      = 1'b1;
            (op == OP_LOAD):   cls.load   = 1'b1;
            (op == OP_STORE):  cls.store  = 1'b1;
            (op == OP_BRANCH): cls.branch = 1'b1;
            default:           cls.bad    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM sequencing the shared multi-cycle datapath
// through FETCH/DECODE/EXECUTE/MEM/WB phases.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] ir,
    input  logic         zero,
    input  logic         mem_ready,
    output logic         mem_req,
    output logic         mem_we,
    output logic         iord,
    output logic         ir_write,
    output logic         pc_write,
    output logic         pc_src,
    output logic [1:0]   alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [1:0]   alu_op,
    output logic         reg_write,
    output logic         mem_to_reg,
    output logic         illegal,
    output logic [3:0]   state
);

    state_t    cur, nxt;
    op_class_t cls;

    wire unused_ir = ^{ir[N-1:7], ir[1:0]};

    multi_cycle_ctrl_opclass u_opclass (
        .op  (ir[6:2]),
        .cls (cls)
    );

    always_ff @(posedge clk) begin
        if (!rst) cur <= S_FETCH;
        else      cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:   nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                nxt = S_ILLEGAL;
                if (cls.r)                   nxt = S_EXEC_R;
                if (cls.load || cls.store)   nxt = S_ADDR;
                if (cls.branch)              nxt = S_BRANCH;
            end
            S_ADDR:    nxt = cls.load ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  nxt = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:  nxt = mem_ready ? S_FETCH : S_MEM_WR;
            S_WB_MEM:  nxt = S_FETCH;
            S_EXEC_R:  nxt = S_WB_ALU;
            S_WB_ALU:  nxt = S_FETCH;
            S_BRANCH:  nxt = S_FETCH;
            S_ILLEGAL: nxt = S_ILLEGAL;
            default:   nxt = S_ILLEGAL;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        state      = cur;
        case (cur)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            S_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_FUNCT;
            end
            S_WB_ALU:  reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                pc_write  = zero;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
        // Reset aborts any transfer in the same cycle.
        if (!rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            alu_src_a  = '0;
            alu_src_b  = '0;
            alu_op     = '0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            illegal    = 1'b0;
            state      = '0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench: per-cycle expected phases built from the
// instruction class, wait counts and the per-phase output table.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic        reg_write, mem_to_reg, illegal;
    logic [3:0]  state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl #(.N(32)) dut (
        .clk(clk), .rst(rst), .ir(ir), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .state(state)
    );

    // {req,we,iord,irw,pcw,pcsrc,a[2],b[2],op[2],rw,m2r,ill}
    function automatic logic [14:0] exp_out(int ph, bit rdy, bit z);
        logic [14:0] v;
        v = '0;
        case (ph)
            0: v = {1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0,
                    2'b00, 2'b01, 2'b00, 3'b000};
            1: v = {6'b0, 2'b01, 2'b10, 2'b00, 3'b000};
            2: v = {6'b0, 2'b10, 2'b10, 2'b00, 3'b000};
            3: v = {6'b101000, 6'b0, 3'b000};
            4: v = {6'b111000, 6'b0, 3'b000};
            5: v = {12'b0, 3'b110};
            6: v = {6'b0, 2'b10, 2'b00, 2'b10, 3'b000};
            7: v = {12'b0, 3'b100};
            8: v = {4'b0000, z, 1'b1, 2'b10, 2'b00, 2'b01, 3'b000};
            9: v = {12'b0, 3'b001};
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic step(input int ph, input bit rdy, input bit z,
                        input bit rv, input string tag);
        logic [14:0] obs, exp;
        logic [3:0]  est;
        @(negedge clk);
        rst       = rv;
        mem_ready = rdy;
        zero      = z;
        #1;
        obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op,
               reg_write, mem_to_reg, illegal};
        exp = rv ? exp_out(ph, rdy, z) : 15'd0;
        est = rv ? 4'(ph) : 4'd0;
        checks++;
        assert (state === est) else begin
            errors++;
            $error("FAIL %s state obs=%0d exp=%0d", tag, state, est);
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s outs ph=%0d obs=%b exp=%b", tag, ph, obs, exp);
        end
    endtask

    // Phase sequence derived from instruction class and wait counts.
    task automatic run_instr(input logic [31:0] instr, input int wf,
                             input int wm, input bit z, input string tag);
        int q[$];
        bit r[$];
        logic [4:0] op;
        op = instr[6:2];
        for (int i = 0; i <= wf; i++) begin
            q.push_back(0); r.push_back(i == wf);
        end
        q.push_back(1); r.push_back(1'($urandom));
        if (op == 5'b01100) begin
            q.push_back(6); r.push_back(1'($urandom));
            q.push_back(7); r.push_back(1'($urandom));
        end else if (op == 5'b00000 || op == 5'b01000) begin
            q.push_back(2); r.push_back(1'($urandom));
            for (int i = 0; i <= wm; i++) begin
                q.push_back(op == 5'b00000 ? 3 : 4);
                r.push_back(i == wm);
            end
            if (op == 5'b00000) begin
                q.push_back(5); r.push_back(1'($urandom));
            end
        end else if (op == 5'b11000) begin
            q.push_back(8); r.push_back(1'($urandom));
        end
        ir = instr;
        foreach (q[i]) step(q[i], r[i], z, 1'b1, tag);
    endtask

    initial begin
        logic [31:0] rir;
        logic [4:0]  ops [4];
        ops[0] = 5'b01100; ops[1] = 5'b00000;
        ops[2] = 5'b01000; ops[3] = 5'b11000;
        rst = 1'b0; ir = '0; zero = 1'b0; mem_ready = 1'b1;

        step(0, 1'b1, 1'b0, 1'b0, "reset0");
        step(0, 1'b0, 1'b1, 1'b0, "reset1");

        run_instr(32'h002081B3, 0, 0, 1'b0, "rtype");
        run_instr(32'h0000A183, 3, 3, 1'b0, "load");
        run_instr(32'h0030A023, 0, 0, 1'b0, "store");
        run_instr(32'h0030A023, 2, 2, 1'b1, "store_wait");
        run_instr(32'h00208463, 0, 0, 1'b1, "beq_taken");
        run_instr(32'h00208463, 1, 0, 1'b0, "beq_not");

        for (int n = 0; n < 40; n++) begin
            rir = $urandom;
            rir[6:2] = ops[$urandom_range(0, 3)];
            run_instr(rir, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), "random");
        end

        // Reset in the middle of a load's memory wait.
        ir = 32'h0000A183;
        step(0, 1'b1, 1'b0, 1'b1, "abort_fetch");
        step(1, 1'b0, 1'b0, 1'b1, "abort_dec");
        step(2, 1'b1, 1'b0, 1'b1, "abort_addr");
        step(3, 1'b0, 1'b0, 1'b1, "abort_wait");
        step(3, 1'b0, 1'b0, 1'b0, "abort_rst");
        step(0, 1'b1, 1'b0, 1'b1, "abort_resume");
        step(1, 1'b0, 1'b0, 1'b1, "abort_resume_dec");
        step(2, 1'b0, 1'b0, 1'b1, "abort_resume_addr");
        step(3, 1'b1, 1'b0, 1'b1, "abort_resume_rd");
        step(5, 1'b0, 1'b0, 1'b1, "abort_resume_wb");

        // Unsupported opcode (LUI) locks up until reset.
        ir = 32'h00000037;
        step(0, 1'b1, 1'b0, 1'b1, "lui_fetch");
        step(1, 1'b0, 1'b0, 1'b1, "lui_dec");
        for (int i = 0; i < 20; i++)
            step(9, 1'($urandom), 1'($urandom), 1'b1, "illegal_hold");
        step(9, 1'b1, 1'b0, 1'b0, "illegal_rst");
        step(0, 1'b0, 1'b0, 1'b1, "illegal_resume");
        step(0, 1'b1, 1'b0, 1'b1, "illegal_resume2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
